fetch_pc_sequencer: RTL

FETCH_PC_SEQUENCER -- requirements
Module: fetch_pc_sequencer

---
 rtl/fetch_pc_sequencer.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/fetch_pc_sequencer.sv
// ---------------------------------------------------------------------------
// fetch_pc_sequencer
//
// Purpose:
//   Generates the instruction fetch address stream for a simple in-order
//   RISC-V front end. A four-state controller (BOOT, FETCH, SQUASH, WAIT)
//   issues one fetch at a time, presents each returned instruction downstream
//   and absorbs branch/jump redirects at any point in the fetch cycle.
//
// Ports:
//   clk             - single clock, rising-edge active
//   rst_n           - asynchronous active-low reset
//   redirect_valid  - a branch/jump target is present on redirect_pc
//   redirect_pc     - redirect target; the low two bits are dropped
//   stall           - downstream cannot accept the presented instruction
//   imem_req        - fetch request, high in FETCH and SQUASH
//   imem_addr       - fetch address (the internal pc register)
//   imem_ack        - imem_rdata is valid for the outstanding request
//   imem_rdata      - fetched instruction word
//   inst_valid      - inst/inst_pc hold a valid instruction
//   inst            - instruction presented downstream
//   inst_pc         - address of inst
// ---------------------------------------------------------------------------
module fetch_pc_sequencer #(
  parameter int INST_MEMORY_ADDRESS_WIDTH = 32,
  parameter int RISC_V_DATA_WIDTH         = 32,
  parameter logic [INST_MEMORY_ADDRESS_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 redirect_valid,
  input  logic [INST_MEMORY_ADDRESS_WIDTH-1:0] redirect_pc,
  input  logic                                 stall,
  output logic                                 imem_req,
  output logic [INST_MEMORY_ADDRESS_WIDTH-1:0] imem_addr,
  input  logic                                 imem_ack,
  input  logic [RISC_V_DATA_WIDTH-1:0]         imem_rdata,
  output logic                                 inst_valid,
  output logic [RISC_V_DATA_WIDTH-1:0]         inst,
  output logic [INST_MEMORY_ADDRESS_WIDTH-1:0] inst_pc
);

  localparam int AW = INST_MEMORY_ADDRESS_WIDTH;
  localparam int DW = RISC_V_DATA_WIDTH;

  typedef enum logic [1:0] {
    ST_BOOT   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_SQUASH = 2'd2,
    ST_WAIT   = 2'd3
  } state_t;

  // Word-align a target: instructions are 4-byte aligned, so the low two
  // bits of any redirect address are forced to zero.
  function automatic logic [AW-1:0] align_pc(input logic [AW-1:0] addr);
    align_pc = addr & ~AW'(3);
  endfunction

  // Registered state
  state_t          state_r;
  logic [AW-1:0]   pc_r;
  logic [AW-1:0]   pending_r;
  logic            req_r;
  logic            inst_valid_r;
  logic [DW-1:0]   inst_r;
  logic [AW-1:0]   inst_pc_r;

  // Next-state values
  state_t          state_s;
  logic [AW-1:0]   pc_s;
  logic [AW-1:0]   pending_s;
  logic            req_s;
  logic            inst_valid_s;
  logic [DW-1:0]   inst_s;
  logic [AW-1:0]   inst_pc_s;
  logic [AW-1:0]   redirect_aligned_s;
  logic [AW-1:0]   pc_inc_s;

  assign redirect_aligned_s = align_pc(redirect_pc);
  // Natural AW-bit truncation gives the modulo-2^AW wrap.
  assign pc_inc_s           = pc_r + AW'(4);

  // Next-state and datapath decode for the fetch controller.
  always_comb begin
    state_s      = state_r;
    pc_s         = pc_r;
    pending_s    = pending_r;
    inst_valid_s = inst_valid_r;
    inst_s       = inst_r;
    inst_pc_s    = inst_pc_r;

    case (state_r)
      ST_BOOT: begin
        // Any imem_ack here belongs to a fetch abandoned by reset.
        state_s = ST_FETCH;
      end

      ST_FETCH: begin
        if (imem_ack) begin
          if (redirect_valid) begin
            // Fetched word is on the wrong path; refetch at the target.
            pc_s    = redirect_aligned_s;
            state_s = ST_FETCH;
          end else begin
            inst_s       = imem_rdata;
            inst_pc_s    = pc_r;
            inst_valid_s = 1'b1;
            pc_s         = pc_inc_s;
            state_s      = ST_WAIT;
          end
        end else if (redirect_valid) begin
          // The request is in flight and imem_addr must stay stable, so the
          // target is parked until the stale response comes back.
          pending_s = redirect_aligned_s;
          state_s   = ST_SQUASH;
        end else begin
          state_s = ST_FETCH;
        end
      end

      ST_SQUASH: begin
        if (imem_ack) begin
          // A redirect arriving with the ack is newer than the parked one.
          if (redirect_valid) begin
            pc_s      = redirect_aligned_s;
            pending_s = redirect_aligned_s;
          end else begin
            pc_s = pending_r;
          end
          state_s = ST_FETCH;
        end else if (redirect_valid) begin
          pending_s = redirect_aligned_s;
          state_s   = ST_SQUASH;
        end else begin
          state_s = ST_SQUASH;
        end
      end

      ST_WAIT: begin
        if (redirect_valid) begin
          // Held instruction is on the wrong path regardless of stall.
          inst_valid_s = 1'b0;
          pc_s         = redirect_aligned_s;
          state_s      = ST_FETCH;
        end else if (!stall) begin
          inst_valid_s = 1'b0;
          state_s      = ST_FETCH;
        end else begin
          state_s = ST_WAIT;
        end
      end

      default: begin
        state_s      = ST_BOOT;
        inst_valid_s = 1'b0;
      end
    endcase

    // imem_req is registered alongside the state so it is high exactly
    // while the controller sits in FETCH or SQUASH.
    if ((state_s == ST_FETCH) || (state_s == ST_SQUASH)) begin
      req_s = 1'b1;
    end else begin
      req_s = 1'b0;
    end
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_BOOT;
      pc_r         <= RESET_PC;
      pending_r    <= '0;
      req_r        <= 1'b0;
      inst_valid_r <= 1'b0;
      inst_r       <= '0;
      inst_pc_r    <= '0;
    end else begin
      state_r      <= state_s;
      pc_r         <= pc_s;
      pending_r    <= pending_s;
      req_r        <= req_s;
      inst_valid_r <= inst_valid_s;
      inst_r       <= inst_s;
      inst_pc_r    <= inst_pc_s;
    end
  end

  assign imem_req   = req_r;
  assign imem_addr  = pc_r;
  assign inst_valid = inst_valid_r;
  assign inst       = inst_r;
  assign inst_pc    = inst_pc_r;

endmodule
